rv_csr_sequencer: RTL

- Sequences Zicsr read-modify-write accesses (CSRRW/CSRRS/CSRRC) onto the single-port CSR file.
- The CSR file exposes a combinational `load`/`store` interface; this block drives it.
- Arbitrates two requesters, round-robin: port 0 is the core execute stage, port 1 is the debug module.
- Each access takes 1–3 access cycles, followed by a held response until the requester accepts it.

---
 rtl/rv_csr_sequencer_if.sv | 46 ++++
 rtl/rv_csr_sequencer.sv | 130 +++++++++++++
 2 files changed

// File: rtl/rv_csr_sequencer_if.sv
// Bundle between the CSR sequencer, its two requesters and the single-port CSR file.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface rv_csr_sequencer_if #(
  parameter bit rv64 = 1'b1
);
  localparam int xlen = rv64 ? 64 : 32;

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][11:0]      req_csr;
  logic [1:0][1:0]       req_op;
  logic [1:0]            req_rd_zero;
  logic [1:0]            req_src_zero;
  logic [1:0][xlen-1:0]  req_value;

  logic [11:0]           csr;
  logic                  load;
  logic                  store;
  logic [xlen-1:0]       store_value;
  logic [xlen-1:0]       load_value;
  logic                  sigill;

  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_id;
  logic [xlen-1:0]       resp_value;
  logic                  resp_sigill;

  modport slave (
    input  req_valid, req_csr, req_op, req_rd_zero, req_src_zero, req_value,
    output req_ready,
    output csr, load, store, store_value,
    input  load_value, sigill,
    output resp_valid, resp_id, resp_value, resp_sigill,
    input  resp_ready
  );

  modport master (
    output req_valid, req_csr, req_op, req_rd_zero, req_src_zero, req_value,
    input  req_ready,
    input  csr, load, store, store_value,
    output load_value, sigill,
    input  resp_valid, resp_id, resp_value, resp_sigill,
    output resp_ready
  );
endinterface

// File: rtl/rv_csr_sequencer.sv
// Zicsr read-modify-write sequencer: round-robin arbitrates two requesters and drives
// one load cycle and/or one store cycle into the CSR file, then holds the response.
module rv_csr_sequencer #(
  parameter bit rv64 = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  rv_csr_sequencer_if.slave  bus
);
  localparam int xlen = rv64 ? 64 : 32;

  localparam logic [1:0] OP_RES = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state_reg, state_next;
  logic              rr_reg;
  logic [11:0]       csr_reg;
  logic [1:0]        op_reg;
  logic              rd_zero_reg;
  logic              src_zero_reg;
  logic              id_reg;
  logic              sigill_reg;
  logic [xlen-1:0]   value_reg;
  logic [xlen-1:0]   old_reg;

  logic              grant_id;
  logic              ready_en;
  logic              accept;
  logic              read_only;
  logic [xlen-1:0]   new_value;

  // rr_reg holds the last granted id; on a tie the other requester wins.
  always_comb begin
    grant_id = 1'b0;
    case (bus.req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~rr_reg;
      default: grant_id = 1'b0;
    endcase
  end

  assign ready_en = (state_reg == IDLE) && !reset && (|bus.req_valid);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign bus.req_ready[gi] = ready_en && (grant_id == 1'(gi));
    end
  endgenerate

  assign accept    = |(bus.req_valid & bus.req_ready);
  assign read_only = (csr_reg[11:10] == 2'b11);

  always_comb begin
    new_value = value_reg;
    case (op_reg)
      OP_RS:   new_value = old_reg | value_reg;
      2'b11:   new_value = old_reg & ~value_reg;
      default: new_value = value_reg;
    endcase
  end

  // Strobes are gated by reset so an abandoned access never reaches the CSR file.
  assign bus.load        = (state_reg == READ) && !reset;
  assign bus.store       = (state_reg == WRITE) && !read_only && !reset;
  assign bus.csr         = (bus.load || bus.store) ? csr_reg : 12'h000;
  assign bus.store_value = bus.store ? new_value : '0;

  assign bus.resp_valid  = (state_reg == RESP) && !reset;
  assign bus.resp_id     = id_reg;
  assign bus.resp_value  = old_reg;
  assign bus.resp_sigill = sigill_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (bus.req_op[grant_id] == OP_RES)
            state_next = RESP;
          else if (bus.req_op[grant_id] == OP_RW && bus.req_rd_zero[grant_id])
            state_next = WRITE;
          else
            state_next = READ;
        end
      end
      READ:    state_next = (op_reg[1] && src_zero_reg) ? RESP : WRITE;
      WRITE:   state_next = RESP;
      RESP:    state_next = bus.resp_ready ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      rr_reg       <= 1'b1;
      csr_reg      <= '0;
      op_reg       <= '0;
      rd_zero_reg  <= 1'b0;
      src_zero_reg <= 1'b0;
      id_reg       <= 1'b0;
      sigill_reg   <= 1'b0;
      value_reg    <= '0;
      old_reg      <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rr_reg       <= grant_id;
            id_reg       <= grant_id;
            csr_reg      <= bus.req_csr[grant_id];
            op_reg       <= bus.req_op[grant_id];
            rd_zero_reg  <= bus.req_rd_zero[grant_id];
            src_zero_reg <= bus.req_src_zero[grant_id];
            value_reg    <= bus.req_value[grant_id];
            old_reg      <= '0;
            sigill_reg   <= (bus.req_op[grant_id] == OP_RES);
          end
        end
        READ:  old_reg    <= bus.load_value;
        WRITE: sigill_reg <= read_only ? 1'b1 : bus.sigill;
        default: ;
      endcase
    end
  end
endmodule
